// File: rtl/hash_function_shared_pipe.sv
// Two-stage shared-EVA hash: splits a tile-group EVA into local X/Y plus an in-tile
// word address under a run-time stripe size, then offsets X/Y by the tile-group origin.
module hash_function_shared_pipe #(
  parameter int width_p        = 16,
  parameter int tg_x_width_p   = 2,
  parameter int tg_y_width_p   = 2,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int addr_width_p   = 10,
  parameter int max_hash_p     = 5,
  localparam int hash_width_lp = $clog2(max_hash_p + 1) + 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [width_p-1:0]        eva_i,
  input  logic [hash_width_lp-1:0]  hash_i,
  input  logic [x_cord_width_p-1:0] tg_origin_x_i,
  input  logic [y_cord_width_p-1:0] tg_origin_y_i,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic [x_cord_width_p-1:0] x_o,
  output logic [y_cord_width_p-1:0] y_o,
  output logic [addr_width_p-1:0]   addr_o,
  output logic                      err_o,
  output logic [7:0]                err_count_o
);

  localparam int tg_w_lp = tg_x_width_p + tg_y_width_p;
  localparam int hi_w_lp = width_p - tg_w_lp;
  localparam logic [hash_width_lp-1:0] max_hash_lp = hash_width_lp'(max_hash_p);

  // Every legal stripe exponent gets its own constant-sliced field decode.
  logic [tg_x_width_p-1:0] lx_cand   [max_hash_p+1];
  logic [tg_y_width_p-1:0] ly_cand   [max_hash_p+1];
  logic [addr_width_p-1:0] addr_cand [max_hash_p+1];

  genvar gi;
  generate
    for (gi = 0; gi <= max_hash_p; gi++) begin : g_hash
      assign lx_cand[gi] = eva_i[gi +: tg_x_width_p];
      assign ly_cand[gi] = eva_i[gi + tg_x_width_p +: tg_y_width_p];
      if (width_p >= tg_w_lp + addr_width_p) begin : g_trunc
        if (gi == 0) begin : g_nolow
          assign addr_cand[gi] = eva_i[tg_w_lp +: addr_width_p];
        end else begin : g_low
          assign addr_cand[gi] = {eva_i[tg_w_lp + gi +: addr_width_p - gi], eva_i[gi-1:0]};
        end
      end else begin : g_pad
        if (gi == 0) begin : g_nolow
          assign addr_cand[gi] = {{(addr_width_p - hi_w_lp){1'b0}}, eva_i[width_p-1:tg_w_lp]};
        end else begin : g_low
          assign addr_cand[gi] = {{(addr_width_p - hi_w_lp){1'b0}},
                                  eva_i[width_p-1:tg_w_lp + gi], eva_i[gi-1:0]};
        end
      end
    end
  endgenerate

  logic                      hash_err;
  logic                      range_err;
  logic [tg_x_width_p-1:0]   lx_sel;
  logic [tg_y_width_p-1:0]   ly_sel;
  logic [addr_width_p-1:0]   addr_sel;

  // An illegal exponent matches no candidate, so its fields fall through as zero.
  always_comb begin
    hash_err = (hash_i > max_hash_lp);
    lx_sel   = '0;
    ly_sel   = '0;
    addr_sel = '0;
    for (int i = 0; i <= max_hash_p; i++) begin
      if (hash_i == hash_width_lp'(i)) begin
        lx_sel   = lx_cand[i];
        ly_sel   = ly_cand[i];
        addr_sel = addr_cand[i];
      end
    end
  end

  generate
    if (width_p > addr_width_p + tg_w_lp) begin : g_range
      assign range_err = |eva_i[width_p-1:addr_width_p + tg_w_lp];
    end else begin : g_norange
      assign range_err = 1'b0;
    end
  endgenerate

  logic                      s1_v;
  logic                      s1_adv;
  logic                      s1_herr;
  logic                      s1_rerr;
  logic [tg_x_width_p-1:0]   s1_lx;
  logic [tg_y_width_p-1:0]   s1_ly;
  logic [addr_width_p-1:0]   s1_addr;
  logic [x_cord_width_p-1:0] s1_ox;
  logic [y_cord_width_p-1:0] s1_oy;

  assign s1_adv  = ~v_o | yumi_i;
  assign ready_o = ~s1_v | s1_adv;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_v    <= 1'b0;
      s1_herr <= 1'b0;
      s1_rerr <= 1'b0;
      s1_lx   <= '0;
      s1_ly   <= '0;
      s1_addr <= '0;
      s1_ox   <= '0;
      s1_oy   <= '0;
    end else if (ready_o) begin
      s1_v <= v_i;
      if (v_i) begin
        s1_herr <= hash_err;
        s1_rerr <= range_err;
        s1_lx   <= lx_sel;
        s1_ly   <= ly_sel;
        s1_addr <= addr_sel;
        s1_ox   <= tg_origin_x_i;
        s1_oy   <= tg_origin_y_i;
      end
    end
  end

  // One extra bit on each sum exposes the carry that flags a coordinate overflow.
  logic [x_cord_width_p:0] x_sum;
  logic [y_cord_width_p:0] y_sum;

  assign x_sum = {1'b0, s1_ox} + (x_cord_width_p + 1)'(s1_lx);
  assign y_sum = {1'b0, s1_oy} + (y_cord_width_p + 1)'(s1_ly);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o         <= 1'b0;
      x_o         <= '0;
      y_o         <= '0;
      addr_o      <= '0;
      err_o       <= 1'b0;
      err_count_o <= '0;
    end else begin
      if (s1_adv) begin
        v_o <= s1_v;
        if (s1_v) begin
          err_o <= s1_herr | s1_rerr | x_sum[x_cord_width_p] | y_sum[y_cord_width_p];
          if (s1_herr) begin
            x_o    <= '0;
            y_o    <= '0;
            addr_o <= '0;
          end else begin
            x_o    <= x_sum[x_cord_width_p-1:0];
            y_o    <= y_sum[y_cord_width_p-1:0];
            addr_o <= s1_addr;
          end
        end
      end
      if (yumi_i && v_o && err_o && (err_count_o != 8'hFF)) begin
        err_count_o <= err_count_o + 8'd1;
      end
    end
  end

  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) (yumi_i |-> v_o));

endmodule

// File: tb/tb_hash_function_shared_pipe.sv
// Scoreboard bench for hash_function_shared_pipe: a driver pushes expected results on
// acceptance, a negedge monitor pops and compares every consumed result.
module tb_hash_function_shared_pipe;

  typedef struct {
    int x;
    int y;
    int addr;
    bit err;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i;
  logic        ready_o;
  logic [15:0] eva_i;
  logic [3:0]  hash_i;
  logic [6:0]  tg_origin_x_i;
  logic [6:0]  tg_origin_y_i;
  logic        v_o;
  logic        yumi_i;
  logic [6:0]  x_o;
  logic [6:0]  y_o;
  logic [9:0]  addr_o;
  logic        err_o;
  logic [7:0]  err_count_o;

  hash_function_shared_pipe dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
    .eva_i(eva_i), .hash_i(hash_i), .tg_origin_x_i(tg_origin_x_i),
    .tg_origin_y_i(tg_origin_y_i), .v_o(v_o), .yumi_i(yumi_i), .x_o(x_o),
    .y_o(y_o), .addr_o(addr_o), .err_o(err_o), .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   passes = 0;
  int   cycle = 0;
  int   yumi_mode = 0;   // 0: never consume, 1: always, 2: random
  int   exp_errs = 0;
  int   txn = 0;
  int   pop_times[$];
  exp_t sb_q[$];
  exp_t mon_e;
  bit   hold_valid = 1'b0;
  logic [6:0] hx, hy;
  logic [9:0] ha;
  logic       he;

  always @(posedge clk_i) cycle++;

  // Reference: slice fields by plain shifts/modulo of the EVA.
  function automatic exp_t model(input int eva, input int h, input int ox, input int oy);
    exp_t e;
    int lx, ly;
    bit rerr, cerr;
    rerr = (eva / 16384) != 0;
    if (h > 5) begin
      e.x = 0; e.y = 0; e.addr = 0; e.err = 1'b1;
      return e;
    end
    lx = (eva >> h) % 4;
    ly = (eva >> (h + 2)) % 4;
    e.addr = (((eva >> (h + 4)) << h) + (eva % (1 << h))) % 1024;
    cerr = (ox + lx > 127) || (oy + ly > 127);
    e.x = (ox + lx) % 128;
    e.y = (oy + ly) % 128;
    e.err = rerr | cerr;
    return e;
  endfunction

  function automatic exp_t mk(input int x, input int y, input int a, input bit er);
    exp_t e;
    e.x = x; e.y = y; e.addr = a; e.err = er;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Consumer: decides yumi just after each edge, only while a result is shown.
  always @(posedge clk_i) begin
    #1;
    yumi_i = v_o && (yumi_mode == 1 || (yumi_mode == 2 && $urandom_range(0, 1) == 1));
  end

  // Monitor: pops on every consumed result, and checks held outputs stay put.
  always @(negedge clk_i) begin
    if (reset_n_i && v_o) begin
      if (hold_valid) begin
        checks++;
        if ({x_o, y_o, addr_o, err_o} === {hx, hy, ha, he}) passes++;
        else $display("FAIL stall_stable: got x=%0d y=%0d addr=%0h err=%0b, required x=%0d y=%0d addr=%0h err=%0b",
                      x_o, y_o, addr_o, err_o, hx, hy, ha, he);
      end
      if (yumi_i) begin
        hold_valid = 1'b0;
        checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL unexpected_result: got x=%0d y=%0d addr=%0h err=%0b, required no result",
                   x_o, y_o, addr_o, err_o);
        end else begin
          mon_e = sb_q.pop_front();
          txn++;
          pop_times.push_back(cycle);
          if (mon_e.err && exp_errs < 255) exp_errs++;
          if (x_o === 7'(mon_e.x) && y_o === 7'(mon_e.y) && addr_o === 10'(mon_e.addr) && err_o === mon_e.err) begin
            passes++;
            $display("txn %0d: x=%0d y=%0d addr=%0h err=%0b ok", txn, x_o, y_o, addr_o, err_o);
          end else begin
            $display("FAIL txn %0d: got x=%0d y=%0d addr=%0h err=%0b, required x=%0d y=%0d addr=%0h err=%0b",
                     txn, x_o, y_o, addr_o, err_o, mon_e.x, mon_e.y, mon_e.addr, mon_e.err);
          end
        end
      end else begin
        hold_valid = 1'b1;
        hx = x_o; hy = y_o; ha = addr_o; he = err_o;
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  // Offer one request (from just after an edge) until accepted; push its expectation.
  task automatic send(input int eva, input int h, input int ox, input int oy,
                      input bit use_exp, input exp_t ex);
    int  n;
    bit  ok;
    v_i = 1'b1;
    eva_i = eva[15:0];
    hash_i = h[3:0];
    tg_origin_x_i = ox[6:0];
    tg_origin_y_i = oy[6:0];
    n = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk_i);
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
      n++;
      if (n > 200) break;
      @(posedge clk_i);
      #1;
    end
    if (ok) sb_q.push_back(use_exp ? ex : model(eva, h, ox, oy));
    else begin
      checks++;
      $display("FAIL accept_timeout: got ready_o=0 for 200 cycles, required acceptance");
    end
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
  endtask

  task automatic send_rand();
    int eva, h;
    eva = $urandom_range(0, 65535);
    if ($urandom_range(0, 3) != 0) eva = eva & 16'h3FFF;
    h = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 15) : $urandom_range(0, 5);
    send(eva, h, $urandom_range(0, 127), $urandom_range(0, 127), 1'b0, mk(0, 0, 0, 0));
  endtask

  task automatic drain();
    int n;
    yumi_mode = 1;
    n = 0;
    while (sb_q.size() > 0 && n < 500) begin
      @(posedge clk_i);
      n++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    reset_n_i = 1'b0;
    v_i = 1'b0;
    yumi_i = 1'b0;
    eva_i = '0;
    hash_i = '0;
    tg_origin_x_i = 7'd16;
    tg_origin_y_i = 7'd8;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_v_o", v_o, 0);
    chk("reset_outputs", {x_o, y_o, addr_o, err_o}, 0);
    chk("reset_err_count", err_count_o, 0);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("ready_after_reset", ready_o, 1);

    // Directed cases with known answers.
    yumi_mode = 1;
    send(16'h0123, 0, 16, 8, 1'b1, mk(19, 8, 'h012, 1'b0));
    chk("latency_not_yet", v_o, 0);
    @(posedge clk_i);
    #1;
    chk("latency_valid", v_o, 1);
    drain();
    send(16'h0123, 2, 16, 8, 1'b1, mk(16, 10, 'h013, 1'b0));
    drain();
    send(16'hBEEF, 6, 16, 8, 1'b1, mk(0, 0, 0, 1'b1));
    drain();
    chk("err_count_hash6", err_count_o, 1);
    send(16'h1234, 7, 16, 8, 1'b1, mk(0, 0, 0, 1'b1));
    send(16'hC000, 0, 16, 8, 1'b1, mk(16, 8, 0, 1'b1));
    send(16'h0003, 0, 126, 8, 1'b1, mk(1, 8, 0, 1'b1));
    drain();
    chk("err_count_directed", err_count_o, 4);

    // Back-to-back streaming with a consumer that never stalls.
    pop_times.delete();
    for (int i = 0; i < 8; i++) send_rand();
    drain();
    chk("stream_count", pop_times.size(), 8);
    if (pop_times.size() == 8) chk("stream_consecutive", pop_times[7] - pop_times[0], 7);

    // Stall: both stages fill, ready drops, outputs hold.
    yumi_mode = 0;
    send_rand();
    send_rand();
    v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_ready_low", ready_o, 0);
    end
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
    drain();

    // Reset with two entries in flight.
    yumi_mode = 0;
    send(16'h0003, 7, 16, 8, 1'b0, mk(0, 0, 0, 0));
    send(16'h0003, 0, 126, 8, 1'b0, mk(0, 0, 0, 0));
    #1;
    reset_n_i = 1'b0;
    #1;
    chk("reset_flush_v_o", v_o, 0);
    sb_q.delete();
    exp_errs = 0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("post_reset_no_stale", v_o, 0);
    chk("post_reset_err_count", err_count_o, 0);

    // Random traffic with random consumer back-pressure.
    yumi_mode = 2;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
      send_rand();
    end
    drain();
    chk("random_err_count", err_count_o, exp_errs);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) send($urandom_range(0, 65535), $urandom_range(8, 15), 16, 8, 1'b1, mk(0, 0, 0, 1'b1));
    drain();
    chk("err_count_saturated", err_count_o, 255);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
